// File: rtl/display_pkg.sv
// Shared constants, segment lookup table and FSM state type for the 4-digit
// multiplexed 7-segment display scanner.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [3:0] AN_OFF   = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; codes 10..15 are not BCD and show a dash
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

    typedef enum logic {IDLE, SCAN} state_t;

    function automatic logic [3:0] digit_anode(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder with a blanking override.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    assign o_seg = i_blank ? SEG_OFF : SEG_TABLE[i_bcd];

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode 4-digit display driver with per-frame snapshot
// and leading-zero blanking. Define DISPLAY_SCANNER_GUARD_EN for anode-off guard cycles.
module display_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Qdata3,
    input  logic [3:0] Qdata2,
    input  logic [3:0] Qdata1,
    input  logic [3:0] Qdata0,
    input  logic       ena,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] TC          = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_START = PW'(REFRESH_DIV - GUARD_CYCLES);
`ifdef DISPLAY_SCANNER_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    state_t          r_state;
    logic [1:0]      r_index;
    logic [PW-1:0]   r_presc;
    logic [3:0]      r_snap [NUM_DIGITS];
    logic            r_blank;
    logic [6:0]      r_seg;
    logic [3:0]      r_an;
    logic            r_frame_tick;

    logic [3:0]              w_qdata [NUM_DIGITS];
    logic [NUM_DIGITS-1:1]   w_zero;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic                    w_guard;
    logic                    w_dig_blank;
    logic [6:0]              w_seg;
    logic [3:0]              w_an;

    assign w_qdata[0] = Qdata0;
    assign w_qdata[1] = Qdata1;
    assign w_qdata[2] = Qdata2;
    assign w_qdata[3] = Qdata3;

    generate
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_zero
            assign w_zero[gi] = (r_snap[gi] == 4'd0);
        end
    endgenerate

    // A digit is a leading zero only if it and every more significant digit are zero
    always_comb begin
        logic run;
        w_lz = '0;
        run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run     = run & w_zero[i];
            w_lz[i] = run;
        end
    end

    assign w_guard     = GUARD_ON && (r_presc >= GUARD_START);
    assign w_dig_blank = w_guard || (r_blank && w_lz[r_index]);
    assign w_an        = w_guard ? AN_OFF : digit_anode(r_index);

    bcd_to_7seg u_dec (
        .i_bcd   (r_snap[r_index]),
        .i_blank (w_dig_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_index      <= 2'd3;
            r_presc      <= '0;
            r_blank      <= 1'b0;
            r_seg        <= SEG_OFF;
            r_an         <= AN_OFF;
            r_frame_tick <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= 4'd0;
        end else begin
            r_frame_tick <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_seg <= SEG_OFF;
                    r_an  <= AN_OFF;
                    if (ena) begin
                        r_state <= SCAN;
                        r_index <= 2'd3;
                        r_presc <= '0;
                        r_blank <= blank_lz;
                        for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= w_qdata[i];
                    end
                end
                SCAN: begin
                    if (!ena) begin
                        r_state <= IDLE;
                        r_index <= 2'd3;
                        r_presc <= '0;
                        r_seg   <= SEG_OFF;
                        r_an    <= AN_OFF;
                    end else begin
                        r_seg <= w_seg;
                        r_an  <= w_an;
                        if (r_presc == TC) begin
                            r_presc <= '0;
                            r_index <= r_index - 2'd1;
                            // Frame boundary: new digits only take effect between frames
                            if (r_index == 2'd0) begin
                                r_frame_tick <= 1'b1;
                                r_blank      <= blank_lz;
                                for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= w_qdata[i];
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scanner.sv
// Directed, table-driven bench for display_scanner with REFRESH_DIV=4, GUARD_CYCLES=1.
module tb_display_scanner;

    localparam int DIV = 4;
    localparam int GC  = 1;
`ifdef DISPLAY_SCANNER_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] q3 = '0, q2 = '0, q1 = '0, q0 = '0;
    logic       ena = 1'b0;
    logic       blz = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       ft;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    display_scanner #(.REFRESH_DIV(DIV), .GUARD_CYCLES(GC)) dut (
        .clk        (clk),
        .rst        (rst),
        .Qdata3     (q3),
        .Qdata2     (q2),
        .Qdata1     (q1),
        .Qdata0     (q0),
        .ena        (ena),
        .blank_lz   (blz),
        .seg        (seg),
        .an         (an),
        .frame_tick (ft)
    );

    typedef struct {
        logic [3:0] d3, d2, d1, d0;
        logic       blz;
        logic [6:0] e3, e2, e1, e0;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_dark(input string tag);
        chk({tag, "_an"},  {4'h0, an}, 8'h0F);
        chk({tag, "_seg"}, {1'b0, seg}, 8'h7F);
        chk({tag, "_ft"},  {7'h0, ft}, 8'h00);
    endtask

    task automatic do_reset;
        rst = 1'b0;
        ena = 1'b0;
        tick;
        check_dark("reset");
        rst = 1'b1;
    endtask

    task automatic enter;
        ena = 1'b1;
        tick;
        chk("entry_an", {4'h0, an}, 8'h0F);
    endtask

    // One full 16-cycle frame of display output, digit 3 first
    task automatic run_frame(input logic [6:0] e3, e2, e1, e0, input string tag);
        logic [6:0] e [4];
        e[3] = e3; e[2] = e2; e[1] = e1; e[0] = e0;
        for (int s = 0; s < 4; s++) begin
            int d;
            d = 3 - s;
            for (int c = 0; c < DIV; c++) begin
                logic       blank;
                logic [3:0] exp_an;
                logic [6:0] exp_seg;
                logic       exp_ft;
                tick;
                blank   = GUARD && (c == DIV - 1);
                exp_an  = blank ? 4'hF : (4'hF ^ (4'h1 << d));
                exp_seg = blank ? 7'h7F : e[d];
                exp_ft  = (d == 0) && (c == DIV - 1);
                chk($sformatf("%s_an_d%0d_c%0d", tag, d, c),  {4'h0, an},  {4'h0, exp_an});
                chk($sformatf("%s_seg_d%0d_c%0d", tag, d, c), {1'b0, seg}, {1'b0, exp_seg});
                chk($sformatf("%s_ft_d%0d_c%0d", tag, d, c),  {7'h0, ft},  {7'h0, exp_ft});
            end
        end
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{4'd9, 4'd6, 4'd7, 4'd5, 1'b0, 7'h10, 7'h02, 7'h78, 7'h12};
        vecs[1] = '{4'd0, 4'd0, 4'd4, 4'd2, 1'b1, 7'h7F, 7'h7F, 7'h19, 7'h24};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        vecs[3] = '{4'd1, 4'd2, 4'hC, 4'd3, 1'b0, 7'h79, 7'h24, 7'h3F, 7'h30};
        vecs[4] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 7'h40, 7'h40, 7'h40, 7'h40};
        vecs[5] = '{4'd0, 4'd5, 4'd0, 4'd8, 1'b1, 7'h7F, 7'h12, 7'h40, 7'h00};
        vecs[6] = '{4'hA, 4'hB, 4'hD, 4'hF, 1'b0, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        vecs[7] = '{4'd0, 4'd0, 4'd7, 4'd0, 1'b1, 7'h7F, 7'h7F, 7'h78, 7'h40};

        for (int v = 0; v < 8; v++) begin
            do_reset;
            q3 = vecs[v].d3; q2 = vecs[v].d2; q1 = vecs[v].d1; q0 = vecs[v].d0;
            blz = vecs[v].blz;
            enter;
            run_frame(vecs[v].e3, vecs[v].e2, vecs[v].e1, vecs[v].e0, $sformatf("v%0d_f0", v));
            run_frame(vecs[v].e3, vecs[v].e2, vecs[v].e1, vecs[v].e0, $sformatf("v%0d_f1", v));
            $display("vector %0d: digits %h%h%h%h blank_lz=%0b, errors so far %0d",
                     v, vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0, vecs[v].blz, n_errors);
        end

        // Mid-frame input change holds until the next snapshot
        do_reset;
        q3 = 4'd1; q2 = 4'd2; q1 = 4'd3; q0 = 4'd4; blz = 1'b0;
        enter;
        q3 = 4'd8;
        run_frame(7'h79, 7'h24, 7'h30, 7'h19, "hold");
        run_frame(7'h00, 7'h24, 7'h30, 7'h19, "newsnap");
        $display("sequence snapshot: errors so far %0d", n_errors);

        // ena dropped mid-slot, then restart with fresh digits
        do_reset;
        q3 = 4'd3; q2 = 4'd1; q1 = 4'd4; q0 = 4'd1; blz = 1'b0;
        enter;
        repeat (6) tick;
        ena = 1'b0;
        tick;
        check_dark("enadrop");
        for (int i = 0; i < 12; i++) begin
            tick;
            check_dark($sformatf("idle_%0d", i));
        end
        q3 = 4'd2; q2 = 4'd0; q1 = 4'd2; q0 = 4'd5;
        enter;
        run_frame(7'h24, 7'h40, 7'h24, 7'h12, "restart");
        $display("sequence ena drop: errors so far %0d", n_errors);

        // Reset mid-frame
        rst = 1'b1;
        q3 = 4'd8; q2 = 4'd8; q1 = 4'd8; q0 = 4'd8;
        do_reset;
        enter;
        repeat (9) tick;
        rst = 1'b0;
        tick;
        check_dark("midrst");
        tick;
        check_dark("midrst_hold");
        q3 = 4'd4; q2 = 4'd3; q1 = 4'd2; q0 = 4'd1;
        rst = 1'b1;
        enter;
        run_frame(7'h19, 7'h30, 7'h24, 7'h79, "postrst");
        $display("sequence mid-frame reset: errors so far %0d", n_errors);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
